// File: rtl/video_overlay_key_bbox.sv
// Overlay key-colour tracker: per-frame bounding box and count of key pixels,
// returned to the host through a valid/ack result register set.
module video_overlay_key_bbox #(
    parameter logic [15:0] KEY_COLOR  = 16'h8745,
    parameter logic [15:0] MATCH_MASK = 16'hFFFF,
    parameter int unsigned X_W        = 11,
    parameter int unsigned Y_W        = 11,
    parameter int unsigned CNT_W      = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic             pix_eol,
    input  logic             pix_eof,
    input  logic [15:0]      pix_data,
    input  logic             res_ack,
    output logic             res_valid,
    output logic             res_empty,
    output logic [X_W-1:0]   res_x_min,
    output logic [X_W-1:0]   res_x_max,
    output logic [Y_W-1:0]   res_y_min,
    output logic [Y_W-1:0]   res_y_max,
    output logic [CNT_W-1:0] res_count,
    output logic             res_overrun,
    output logic             frame_err
);

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    logic             state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;

    logic             found_q, found_d;
    logic [X_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
    logic [Y_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             commit_q, commit_d;
    logic             frame_err_q, frame_err_d;

    logic             res_valid_q, res_valid_d;
    logic             res_empty_q, res_empty_d;
    logic             res_overrun_q, res_overrun_d;
    logic [X_W-1:0]   res_x_min_q, res_x_min_d, res_x_max_q, res_x_max_d;
    logic [Y_W-1:0]   res_y_min_q, res_y_min_d, res_y_max_q, res_y_max_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;

    logic             take;
    logic             restart;
    logic             hit;
    logic [X_W-1:0]   px;
    logic [Y_W-1:0]   py;
    logic             b_found;
    logic [X_W-1:0]   b_xmin, b_xmax;
    logic [Y_W-1:0]   b_ymin, b_ymax;
    logic [CNT_W-1:0] b_cnt;

    // A sof pixel always restarts the frame, so the accumulator base is forced to
    // the cleared state for that pixel instead of using the running values.
    always_comb begin
        take    = pix_valid & (pix_sof | (state_q == ST_ACTIVE));
        restart = pix_valid & pix_sof;
        hit     = ((pix_data & MATCH_MASK) == (KEY_COLOR & MATCH_MASK));
        px      = restart ? '0 : x_q;
        py      = restart ? '0 : y_q;
        b_found = restart ? 1'b0 : found_q;
        b_xmin  = restart ? '0 : xmin_q;
        b_xmax  = restart ? '0 : xmax_q;
        b_ymin  = restart ? '0 : ymin_q;
        b_ymax  = restart ? '0 : ymax_q;
        b_cnt   = restart ? '0 : cnt_q;

        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        found_d     = found_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        cnt_d       = cnt_q;
        commit_d    = 1'b0;
        frame_err_d = restart & (state_q == ST_ACTIVE);

        if (take) begin
            state_d = ST_ACTIVE;
            found_d = b_found | hit;
            xmin_d  = b_xmin;
            xmax_d  = b_xmax;
            ymin_d  = b_ymin;
            ymax_d  = b_ymax;
            cnt_d   = b_cnt;
            if (hit) begin
                if (!b_found) begin
                    xmin_d = px;
                    xmax_d = px;
                    ymin_d = py;
                    ymax_d = py;
                end else begin
                    if (px < b_xmin) xmin_d = px;
                    if (px > b_xmax) xmax_d = px;
                    if (py < b_ymin) ymin_d = py;
                    if (py > b_ymax) ymax_d = py;
                end
                cnt_d = (b_cnt == '1) ? b_cnt : b_cnt + CNT_W'(1);
            end

            if (pix_eol) begin
                x_d = '0;
                y_d = (py == '1) ? py : py + Y_W'(1);
            end else begin
                x_d = (px == '1) ? px : px + X_W'(1);
                y_d = py;
            end

            if (pix_eof) begin
                state_d  = ST_IDLE;
                x_d      = '0;
                y_d      = '0;
                commit_d = 1'b1;
            end
        end
    end

    // Commit takes the accumulators one edge after eof; an ack in the same cycle
    // retires the old result, so the new one is never flagged as an overrun.
    always_comb begin
        res_valid_d   = res_valid_q;
        res_overrun_d = res_overrun_q;
        res_empty_d   = res_empty_q;
        res_x_min_d   = res_x_min_q;
        res_x_max_d   = res_x_max_q;
        res_y_min_d   = res_y_min_q;
        res_y_max_d   = res_y_max_q;
        res_count_d   = res_count_q;

        if (res_ack && res_valid_q) begin
            res_valid_d   = 1'b0;
            res_overrun_d = 1'b0;
        end

        if (commit_q) begin
            res_valid_d = 1'b1;
            if (res_valid_q && !res_ack) res_overrun_d = 1'b1;
            res_empty_d = ~found_q;
            res_x_min_d = found_q ? xmin_q : '0;
            res_x_max_d = found_q ? xmax_q : '0;
            res_y_min_d = found_q ? ymin_q : '0;
            res_y_max_d = found_q ? ymax_q : '0;
            res_count_d = found_q ? cnt_q  : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            found_q       <= 1'b0;
            xmin_q        <= '0;
            xmax_q        <= '0;
            ymin_q        <= '0;
            ymax_q        <= '0;
            cnt_q         <= '0;
            commit_q      <= 1'b0;
            frame_err_q   <= 1'b0;
            res_valid_q   <= 1'b0;
            res_empty_q   <= 1'b0;
            res_overrun_q <= 1'b0;
            res_x_min_q   <= '0;
            res_x_max_q   <= '0;
            res_y_min_q   <= '0;
            res_y_max_q   <= '0;
            res_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            found_q       <= found_d;
            xmin_q        <= xmin_d;
            xmax_q        <= xmax_d;
            ymin_q        <= ymin_d;
            ymax_q        <= ymax_d;
            cnt_q         <= cnt_d;
            commit_q      <= commit_d;
            frame_err_q   <= frame_err_d;
            res_valid_q   <= res_valid_d;
            res_empty_q   <= res_empty_d;
            res_overrun_q <= res_overrun_d;
            res_x_min_q   <= res_x_min_d;
            res_x_max_q   <= res_x_max_d;
            res_y_min_q   <= res_y_min_d;
            res_y_max_q   <= res_y_max_d;
            res_count_q   <= res_count_d;
        end
    end

    assign res_valid   = res_valid_q;
    assign res_empty   = res_empty_q;
    assign res_x_min   = res_x_min_q;
    assign res_x_max   = res_x_max_q;
    assign res_y_min   = res_y_min_q;
    assign res_y_max   = res_y_max_q;
    assign res_count   = res_count_q;
    assign res_overrun = res_overrun_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_video_overlay_key_bbox.sv
// Bench for video_overlay_key_bbox: two instances (full and high-byte match mask)
// share one pixel stream; a per-pixel reference model feeds result scoreboards.
module tb_video_overlay_key_bbox;

    localparam logic [15:0] KEY = 16'h8745;
    localparam logic [15:0] BG  = 16'h1080;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid, pix_sof, pix_eol, pix_eof;
    logic [15:0] pix_data;
    logic        res_ack;

    logic        valid_a, empty_a, ovr_a, ferr_a;
    logic [10:0] x0_a, x1_a, y0_a, y1_a;
    logic [21:0] cnt_a;
    logic        valid_b, empty_b, ovr_b, ferr_b;
    logic [10:0] x0_b, x1_b, y0_b, y1_b;
    logic [21:0] cnt_b;

    always #5 clk = ~clk;

    video_overlay_key_bbox dut_a (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_data(pix_data), .res_ack(res_ack),
        .res_valid(valid_a), .res_empty(empty_a), .res_x_min(x0_a), .res_x_max(x1_a),
        .res_y_min(y0_a), .res_y_max(y1_a), .res_count(cnt_a),
        .res_overrun(ovr_a), .frame_err(ferr_a)
    );

    video_overlay_key_bbox #(.MATCH_MASK(16'hFF00)) dut_b (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_eof(pix_eof), .pix_data(pix_data), .res_ack(res_ack),
        .res_valid(valid_b), .res_empty(empty_b), .res_x_min(x0_b), .res_x_max(x1_b),
        .res_y_min(y0_b), .res_y_max(y1_b), .res_count(cnt_b),
        .res_overrun(ovr_b), .frame_err(ferr_b)
    );

    typedef struct {
        logic        empty;
        logic [10:0] x0, x1, y0, y1;
        logic [21:0] cnt;
    } res_t;

    res_t exp_a[$];
    res_t exp_b[$];

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_mask [2] = '{16'hFFFF, 16'hFF00};
    logic        m_active;
    int          m_x, m_y;
    logic        m_found [2];
    int          m_x0 [2], m_x1 [2], m_y0 [2], m_y1 [2], m_cnt [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_pix(input logic sof, input logic eol, input logic eof, input logic [15:0] d);
        res_t r;
        if (!m_active && !sof) return;
        if (sof) begin
            m_active = 1'b1;
            m_x = 0;
            m_y = 0;
            for (int k = 0; k < 2; k++) begin
                m_found[k] = 1'b0;
                m_x0[k] = 0; m_x1[k] = 0; m_y0[k] = 0; m_y1[k] = 0; m_cnt[k] = 0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if ((d & m_mask[k]) == (KEY & m_mask[k])) begin
                if (!m_found[k]) begin
                    m_x0[k] = m_x; m_x1[k] = m_x; m_y0[k] = m_y; m_y1[k] = m_y;
                end else begin
                    if (m_x < m_x0[k]) m_x0[k] = m_x;
                    if (m_x > m_x1[k]) m_x1[k] = m_x;
                    if (m_y < m_y0[k]) m_y0[k] = m_y;
                    if (m_y > m_y1[k]) m_y1[k] = m_y;
                end
                m_found[k] = 1'b1;
                m_cnt[k]++;
            end
        end
        if (eol) begin
            m_x = 0;
            m_y++;
        end else begin
            m_x++;
        end
        if (eof) begin
            for (int k = 0; k < 2; k++) begin
                r.empty = !m_found[k];
                r.x0 = 11'(m_x0[k]); r.x1 = 11'(m_x1[k]);
                r.y0 = 11'(m_y0[k]); r.y1 = 11'(m_y1[k]);
                r.cnt = 22'(m_cnt[k]);
                if (k == 0) exp_a.push_back(r);
                else        exp_b.push_back(r);
            end
            m_active = 1'b0;
        end
    endtask

    task automatic send_pix(input logic v, input logic sof, input logic eol, input logic eof,
                            input logic [15:0] d, input logic ack);
        pix_valid = v; pix_sof = sof; pix_eol = eol; pix_eof = eof;
        pix_data = d; res_ack = ack;
        if (v) model_pix(sof, eol, eof, d);
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_eof = 1'b0; res_ack = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int kx0, input int kx1,
                              input int ky0, input int ky1, input logic [15:0] kval,
                              input int resof_row, input int stop_row);
        logic [15:0] d;
        logic        s;
        for (int r = 0; r < h; r++) begin
            if (stop_row >= 0 && r == stop_row) return;
            for (int c = 0; c < w; c++) begin
                d = (c >= kx0 && c <= kx1 && r >= ky0 && r <= ky1) ? kval : BG;
                s = (r == 0 && c == 0) || (r == resof_row && c == 0);
                send_pix(1'b1, s, c == w - 1, (r == h - 1) && (c == w - 1), d, 1'b0);
                if (r == resof_row && r != 0 && c == 0) begin
                    check_eq("frame_err_pulse_a", ferr_a, 1);
                    check_eq("frame_err_pulse_b", ferr_b, 1);
                end
                if (r == resof_row && r != 0 && c == 1) check_eq("frame_err_clear", ferr_a, 0);
            end
        end
    endtask

    task automatic expect_commit(input logic ack, input logic prev_valid, input logic exp_ovr);
        res_t r;
        check_eq("valid_before_commit", valid_a, prev_valid);
        send_pix(1'b0, 1'b0, 1'b0, 1'b0, BG, ack);
        check_eq("valid_a", valid_a, 1);
        check_eq("valid_b", valid_b, 1);
        check_eq("overrun_a", ovr_a, exp_ovr);
        if (exp_a.size() > 0) begin
            r = exp_a.pop_front();
            check_eq("empty_a", empty_a, r.empty);
            check_eq("x_min_a", x0_a, r.x0);
            check_eq("x_max_a", x1_a, r.x1);
            check_eq("y_min_a", y0_a, r.y0);
            check_eq("y_max_a", y1_a, r.y1);
            check_eq("count_a", cnt_a, r.cnt);
        end
        if (exp_b.size() > 0) begin
            r = exp_b.pop_front();
            check_eq("empty_b", empty_b, r.empty);
            check_eq("x_min_b", x0_b, r.x0);
            check_eq("x_max_b", x1_b, r.x1);
            check_eq("y_min_b", y0_b, r.y0);
            check_eq("y_max_b", y1_b, r.y1);
            check_eq("count_b", cnt_b, r.cnt);
        end
    endtask

    task automatic send_ack();
        send_pix(1'b0, 1'b0, 1'b0, 1'b0, BG, 1'b1);
        check_eq("ack_valid", valid_a, 0);
        check_eq("ack_overrun", ovr_a, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_active = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0; pix_eof = 1'b0;
        pix_data = BG; res_ack = 1'b0;
        m_active = 1'b0; m_x = 0; m_y = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", valid_a, 0);
        check_eq("rst_empty", empty_a, 0);
        check_eq("rst_x_min", x0_a, 0);
        check_eq("rst_x_max", x1_a, 0);
        check_eq("rst_y_max", y1_a, 0);
        check_eq("rst_count", cnt_a, 0);
        check_eq("rst_overrun", ovr_a, 0);
        check_eq("rst_frame_err", ferr_a, 0);
        rst = 1'b0;
        send_pix(1'b0, 1'b0, 1'b0, 1'b0, BG, 1'b0);

        // Large frame with a 50x20 key block
        send_frame(160, 224, 100, 149, 200, 219, KEY, -1, -1);
        expect_commit(1'b0, 1'b0, 1'b0);
        check_eq("big_x_min", x0_a, 100);
        check_eq("big_x_max", x1_a, 149);
        check_eq("big_y_min", y0_a, 200);
        check_eq("big_y_max", y1_a, 219);
        check_eq("big_count", cnt_a, 1000);
        check_eq("big_empty", empty_a, 0);
        send_ack();

        // Frame without key pixels
        send_frame(16, 8, 0, -1, 0, -1, KEY, -1, -1);
        expect_commit(1'b0, 1'b0, 1'b0);
        check_eq("nokey_empty", empty_a, 1);
        check_eq("nokey_count", cnt_a, 0);
        send_ack();

        // Two frames without ack
        send_frame(16, 8, 3, 3, 2, 2, KEY, -1, -1);
        expect_commit(1'b0, 1'b0, 1'b0);
        send_frame(16, 8, 5, 7, 4, 6, KEY, -1, -1);
        expect_commit(1'b0, 1'b1, 1'b1);
        check_eq("ovr_x_min", x0_a, 5);
        check_eq("ovr_count", cnt_a, 9);
        send_ack();

        // sof reissued mid-frame at row 5; key rows 2..4 must be discarded
        send_frame(16, 12, 4, 6, 2, 8, KEY, 5, -1);
        expect_commit(1'b0, 1'b0, 1'b0);
        check_eq("resof_count", cnt_a, 12);
        check_eq("resof_y_min", y0_a, 0);
        check_eq("resof_y_max", y1_a, 3);
        send_ack();

        // Reset mid-frame, then eof without sof
        send_frame(16, 8, 2, 5, 1, 6, KEY, -1, 4);
        do_reset();
        send_pix(1'b1, 1'b0, 1'b1, 1'b1, KEY, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_pix(1'b0, 1'b0, 1'b0, 1'b0, BG, 1'b0);
            check_eq("rst_eof_valid_a", valid_a, 0);
            check_eq("rst_eof_valid_b", valid_b, 0);
        end
        send_frame(16, 8, 2, 5, 1, 6, KEY, -1, -1);
        expect_commit(1'b0, 1'b0, 1'b0);
        check_eq("post_rst_count", cnt_a, 24);

        // Single-pixel frame (sof+eof) over an unacked result
        send_frame(1, 1, 0, 0, 0, 0, KEY, -1, -1);
        expect_commit(1'b0, 1'b1, 1'b1);
        check_eq("one_pix_count", cnt_a, 1);

        // Masked match, ack in the commit cycle
        send_frame(8, 4, 2, 3, 1, 1, 16'h87FF, -1, -1);
        expect_commit(1'b1, 1'b1, 1'b0);
        check_eq("mask_b_count", cnt_b, 2);
        check_eq("mask_b_x_min", x0_b, 2);
        check_eq("mask_a_empty", empty_a, 1);
        send_ack();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
